// File: rtl/bypass_chain_tx.sv
// Serial programmer for the wake-up bypass shift chain: shifts a parallel word in MSB-first, then strobes it into the holding stage.
// Optional readback of the previous shift-stage contents is built when BYPASS_TX_READBACK_EN is defined.
module bypass_chain_tx #(
   parameter int CHAIN_LEN = 24,
   parameter int SETTLE    = 1
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 cfg_valid_i,
   output logic                 cfg_ready_o,
   input  logic [CHAIN_LEN-1:0] cfg_data_i,
   output logic                 bypass_data_o,
   output logic                 bypass_en_o,
   output logic                 bypass_shift_o,
   input  logic                 bypass_data_i,
   output logic                 busy_o,
   output logic                 done_o,
   output logic [CHAIN_LEN-1:0] rdata_o,
   output logic                 rdata_valid_o
);

   localparam int               CNT_W       = $clog2(CHAIN_LEN + 1);
   localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(CHAIN_LEN - 1);
   localparam logic [3:0]       SETTLE_LAST = (SETTLE > 0) ? 4'(SETTLE - 1) : 4'd0;

   typedef enum logic [2:0] {
      S_IDLE,
      S_SHIFT,
      S_SETTLE_WAIT,
      S_LATCH,
      S_DONE
   } state_t;

   state_t               r_state;
   state_t               w_next;
   logic [CHAIN_LEN-1:0] r_tx;
   logic [CNT_W-1:0]     r_cnt;
   logic [3:0]           r_settle_cnt;
   logic                 r_rst_done;
   logic                 w_accept;

   // Ready is held low while reset is asserted and rises only after the first non-reset edge.
   assign cfg_ready_o    = (r_state == S_IDLE) && r_rst_done;
   assign busy_o         = (r_state != S_IDLE);
   assign bypass_en_o    = (r_state == S_SHIFT);
   assign bypass_data_o  = (r_state == S_SHIFT) && r_tx[CHAIN_LEN-1];
   assign bypass_shift_o = (r_state == S_LATCH);
   assign done_o         = (r_state == S_DONE);
   assign w_accept       = cfg_valid_i && cfg_ready_o;

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_IDLE:        if (w_accept) w_next = S_SHIFT;
         S_SHIFT:       if (r_cnt == CNT_LAST) w_next = (SETTLE > 0) ? S_SETTLE_WAIT : S_LATCH;
         S_SETTLE_WAIT: if (r_settle_cnt == SETTLE_LAST) w_next = S_LATCH;
         S_LATCH:       w_next = S_DONE;
         S_DONE:        w_next = S_IDLE;
         default:       w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state    <= S_IDLE;
         r_rst_done <= 1'b0;
      end else begin
         r_state    <= w_next;
         r_rst_done <= 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_tx         <= '0;
         r_cnt        <= '0;
         r_settle_cnt <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_tx  <= cfg_data_i;
                  r_cnt <= '0;
               end
            end
            S_SHIFT: begin
               r_tx         <= {r_tx[CHAIN_LEN-2:0], 1'b0};
               r_cnt        <= r_cnt + CNT_W'(1);
               r_settle_cnt <= '0;
            end
            S_SETTLE_WAIT: r_settle_cnt <= r_settle_cnt + 4'd1;
            default: ;
         endcase
      end
   end

`ifdef BYPASS_TX_READBACK_EN
   logic [CHAIN_LEN-1:0] r_rx;
   logic [CHAIN_LEN-1:0] r_rdata;
   logic                 r_rdata_valid;

   // NOTE: r_rx has no reset; every transfer overwrites all CHAIN_LEN bits before it is copied out.
   always_ff @(posedge clk_i) begin
      if (bypass_en_o) r_rx <= {r_rx[CHAIN_LEN-2:0], bypass_data_i};
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_rdata       <= '0;
         r_rdata_valid <= 1'b0;
      end else begin
         r_rdata_valid <= (r_state == S_LATCH);
         if (r_state == S_LATCH) r_rdata <= r_rx;
      end
   end

   assign rdata_o       = r_rdata;
   assign rdata_valid_o = r_rdata_valid;
`else
   logic w_unused;

   assign w_unused      = bypass_data_i;
   assign rdata_o       = '0;
   assign rdata_valid_o = 1'b0;
`endif

endmodule
